ysyx_25040111_arbiter: RTL and testbench



---
 rtl/ysyx_25040111_arbiter_if.sv | 52 +++++
 rtl/ysyx_25040111_arbiter.sv | 164 ++++++++++++++++
 tb/tb_ysyx_25040111_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_25040111_arbiter_if.sv
// AXI4 channel bundle shared by the IFU, LSU and downstream memory/IO port.
// The master modport is the side that issues requests; slave is the responder.
interface ysyx_25040111_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          arvalid;
   logic          arready;
   logic [AW-1:0] araddr;
   logic [3:0]    arid;
   logic [7:0]    arlen;
   logic [2:0]    arsize;
   logic [1:0]    arburst;

   logic          rvalid;
   logic          rready;
   logic [DW-1:0] rdata;
   logic [1:0]    rresp;
   logic          rlast;

   logic          awvalid;
   logic          awready;
   logic [AW-1:0] awaddr;
   logic [3:0]    awid;
   logic [7:0]    awlen;
   logic [2:0]    awsize;
   logic [1:0]    awburst;

   logic            wvalid;
   logic            wready;
   logic [DW-1:0]   wdata;
   logic [DW/8-1:0] wstrb;
   logic            wlast;

   logic          bvalid;
   logic          bready;
   logic [1:0]    bresp;

   modport master (
      output arvalid, araddr, arid, arlen, arsize, arburst, rready,
             awvalid, awaddr, awid, awlen, awsize, awburst,
             wvalid, wdata, wstrb, wlast, bready,
      input  arready, rvalid, rdata, rresp, rlast, awready, wready, bvalid, bresp
   );

   modport slave (
      input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
             awvalid, awaddr, awid, awlen, awsize, awburst,
             wvalid, wdata, wstrb, wlast, bready,
      output arready, rvalid, rdata, rresp, rlast, awready, wready, bvalid, bresp
   );
endinterface

// File: rtl/ysyx_25040111_arbiter.sv
// Two-master (IFU read-only, LSU read + single-beat write) to one-slave AXI4
// arbiter. One transaction outstanding at a time; the granted master's
// channels are passed through combinationally.
// Optional macro YSYX_25040111_ARB_RR_EN: round-robin between the two read
// masters on a tie (writes still win). Undefined: LSU read beats IFU read.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no grant; all handshakes blocked, arbitration evaluated
// RD_IFU | IFU owns AR/R until the rlast beat is accepted
// RD_LSU | LSU owns AR/R until the rlast beat is accepted
// WR_LSU | LSU owns AW/W/B until the write response is accepted
module ysyx_25040111_arbiter #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input logic                     clk,
   input logic                     rst,
   ysyx_25040111_arbiter_if.slave  ifu,
   ysyx_25040111_arbiter_if.slave  lsu,
   ysyx_25040111_arbiter_if.master mem
);
   typedef enum logic [1:0] {IDLE, RD_IFU, RD_LSU, WR_LSU} st_t;

   st_t st;
   st_t st_nxt;

`ifdef YSYX_25040111_ARB_RR_EN
   // 1: IFU was the last read served, so the LSU wins the next read tie.
   // Starts at 1 so the first tie after reset goes to the LSU.
   logic last_rd;

   // Remember which reader completed last.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_rd <= 1'b1;
      end else if (st == RD_IFU && st_nxt == IDLE) begin
         last_rd <= 1'b1;
      end else if (st == RD_LSU && st_nxt == IDLE) begin
         last_rd <= 1'b0;
      end
   end
`endif

   // State register; reset drops any in-flight transaction.
   always_ff @(posedge clk) begin
      if (rst) begin
         st <= IDLE;
      end else begin
         st <= st_nxt;
      end
   end

   // Next-state arbitration and channel steering for the granted master.
   always_comb begin
      st_nxt        = st;

      mem.arvalid   = 1'b0;
      mem.araddr    = {AW{1'b0}};
      mem.arid      = 4'h0;
      mem.arlen     = 8'h0;
      mem.arsize    = 3'h0;
      mem.arburst   = 2'b00;
      mem.rready    = 1'b0;
      mem.awvalid   = 1'b0;
      mem.awaddr    = {AW{1'b0}};
      mem.awid      = 4'h0;
      mem.awlen     = 8'h0;
      mem.awsize    = 3'h0;
      mem.awburst   = 2'b01;
      mem.wvalid    = 1'b0;
      mem.wdata     = {DW{1'b0}};
      mem.wstrb     = '0;
      mem.wlast     = 1'b0;
      mem.bready    = 1'b0;

      ifu.arready   = 1'b0;
      ifu.rvalid    = 1'b0;
      ifu.rdata     = {DW{1'b0}};
      ifu.rresp     = 2'b00;
      ifu.rlast     = 1'b0;
      ifu.awready   = 1'b0;
      ifu.wready    = 1'b0;
      ifu.bvalid    = 1'b0;
      ifu.bresp     = 2'b00;

      lsu.arready   = 1'b0;
      lsu.rvalid    = 1'b0;
      lsu.rdata     = {DW{1'b0}};
      lsu.rresp     = 2'b00;
      lsu.rlast     = 1'b0;
      lsu.awready   = 1'b0;
      lsu.wready    = 1'b0;
      lsu.bvalid    = 1'b0;
      lsu.bresp     = 2'b00;

      case (st)
         IDLE: begin
            if (lsu.awvalid && lsu.wvalid) begin
               st_nxt = WR_LSU;
`ifdef YSYX_25040111_ARB_RR_EN
            end else if (lsu.arvalid && ifu.arvalid) begin
               st_nxt = last_rd ? RD_LSU : RD_IFU;
`endif
            end else if (lsu.arvalid) begin
               st_nxt = RD_LSU;
            end else if (ifu.arvalid) begin
               st_nxt = RD_IFU;
            end
         end
         RD_IFU: begin
            mem.arvalid = ifu.arvalid;
            mem.araddr  = ifu.araddr;
            mem.arlen   = ifu.arlen;
            mem.arsize  = ifu.arsize;
            mem.arburst = ifu.arburst;
            ifu.arready = mem.arready;
            mem.rready  = ifu.rready;
            ifu.rvalid  = mem.rvalid;
            ifu.rdata   = mem.rdata;
            ifu.rresp   = mem.rresp;
            ifu.rlast   = mem.rlast;
            if (mem.rvalid && ifu.rready && mem.rlast) st_nxt = IDLE;
         end
         RD_LSU: begin
            mem.arvalid = lsu.arvalid;
            mem.araddr  = lsu.araddr;
            mem.arlen   = lsu.arlen;
            mem.arsize  = lsu.arsize;
            mem.arburst = lsu.arburst;
            lsu.arready = mem.arready;
            mem.rready  = lsu.rready;
            lsu.rvalid  = mem.rvalid;
            lsu.rdata   = mem.rdata;
            lsu.rresp   = mem.rresp;
            lsu.rlast   = mem.rlast;
            if (mem.rvalid && lsu.rready && mem.rlast) st_nxt = IDLE;
         end
         WR_LSU: begin
            mem.awvalid = lsu.awvalid;
            mem.awaddr  = lsu.awaddr;
            mem.awsize  = lsu.awsize;
            lsu.awready = mem.awready;
            mem.wvalid  = lsu.wvalid;
            mem.wdata   = lsu.wdata;
            mem.wstrb   = lsu.wstrb;
            mem.wlast   = lsu.wlast;
            lsu.wready  = mem.wready;
            mem.bready  = lsu.bready;
            lsu.bvalid  = mem.bvalid;
            lsu.bresp   = mem.bresp;
            if (mem.bvalid && lsu.bready) st_nxt = IDLE;
         end
         default: st_nxt = IDLE;
      endcase
   end

   // IDs and the IFU write channels are fixed downstream, so these inputs are ignored.
   logic unused_ok;
   assign unused_ok = ^{ifu.arid, ifu.awvalid, ifu.awaddr, ifu.awid, ifu.awlen,
                        ifu.awsize, ifu.awburst, ifu.wvalid, ifu.wdata, ifu.wstrb,
                        ifu.wlast, ifu.bready, lsu.arid, lsu.awid, lsu.awlen,
                        lsu.awburst};
endmodule

// File: tb/tb_ysyx_25040111_arbiter.sv
// Self-checking bench for ysyx_25040111_arbiter: vector table of arbitration
// decisions, directed corner sequences, and randomized traffic checked against
// a request-queue model of the grant rules.
module tb_ysyx_25040111_arbiter;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ysyx_25040111_arbiter_if ifu ();
   ysyx_25040111_arbiter_if lsu ();
   ysyx_25040111_arbiter_if mem ();

   ysyx_25040111_arbiter #(.AW(32), .DW(32)) dut (
      .clk (clk),
      .rst (rst),
      .ifu (ifu),
      .lsu (lsu),
      .mem (mem)
   );

   int n_pass = 0;
   int n_tot  = 0;

   // Reference model state: who is waiting, and which reader was served last.
   bit          pend_ifu, pend_lsu, pend_wr;
   int          last_served;   // 0 = IFU, 1 = LSU
   logic [31:0] ifu_addr, lsu_addr, aw_addr, w_data;
   int          ifu_len, lsu_len;

   typedef struct {
      bit ir;
      bit lr;
      bit wr;
      int exp;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   task automatic chk_idle(input string nm);
      chk(nm, {mem.arvalid, mem.rready, mem.awvalid, mem.wvalid, mem.bready,
               ifu.arready, ifu.rvalid, lsu.arready, lsu.rvalid,
               lsu.awready, lsu.wready, lsu.bvalid}, 64'h0);
   endtask

   // Grant rule: write first; tie between readers by priority or round-robin.
   function automatic int model_pick();
      if (pend_wr) return 2;
      if (pend_lsu && pend_ifu) begin
`ifdef YSYX_25040111_ARB_RR_EN
         return (last_served == 0) ? 1 : 0;
`else
         return 1;
`endif
      end
      if (pend_lsu) return 1;
      if (pend_ifu) return 0;
      return -1;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      ifu.arvalid = 0; ifu.araddr = 0; ifu.arid = 0; ifu.arlen = 0; ifu.arsize = 3'd2;
      ifu.arburst = 2'b01; ifu.rready = 0; ifu.awvalid = 0; ifu.awaddr = 0; ifu.awid = 0;
      ifu.awlen = 0; ifu.awsize = 0; ifu.awburst = 0; ifu.wvalid = 0; ifu.wdata = 0;
      ifu.wstrb = 0; ifu.wlast = 0; ifu.bready = 0;
      lsu.arvalid = 0; lsu.araddr = 0; lsu.arid = 0; lsu.arlen = 0; lsu.arsize = 3'd2;
      lsu.arburst = 2'b01; lsu.rready = 0; lsu.awvalid = 0; lsu.awaddr = 0; lsu.awid = 0;
      lsu.awlen = 0; lsu.awsize = 3'd2; lsu.awburst = 2'b01; lsu.wvalid = 0; lsu.wdata = 0;
      lsu.wstrb = 0; lsu.wlast = 0; lsu.bready = 0;
      mem.arready = 0; mem.rvalid = 0; mem.rdata = 0; mem.rresp = 0; mem.rlast = 0;
      mem.awready = 0; mem.wready = 0; mem.bvalid = 0; mem.bresp = 0;
      pend_ifu = 0; pend_lsu = 0; pend_wr = 0; last_served = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk_idle("reset_idle");
   endtask

   task automatic req_ifu(input logic [31:0] a, input int len);
      ifu_addr = a; ifu_len = len;
      ifu.araddr = a; ifu.arlen = len[7:0]; ifu.arburst = 2'b01; ifu.arvalid = 1; pend_ifu = 1;
   endtask

   task automatic req_lsu(input logic [31:0] a, input int len);
      lsu_addr = a; lsu_len = len;
      lsu.araddr = a; lsu.arlen = len[7:0]; lsu.arburst = 2'b01; lsu.arvalid = 1; pend_lsu = 1;
   endtask

   task automatic req_wr(input logic [31:0] a, input logic [31:0] d);
      aw_addr = a; w_data = d;
      lsu.awaddr = a; lsu.awsize = 3'd2; lsu.wdata = d; lsu.wstrb = 4'hf; lsu.wlast = 1;
      lsu.awvalid = 1; lsu.wvalid = 1; pend_wr = 1;
   endtask

   // Called in a decision cycle; runs the granted transaction to completion
   // and ends in the following bubble cycle.
   task automatic serve(input int aw_dly, input int w_dly, input logic [1:0] resp,
                        input logic [31:0] d0, input bit mid_lsu, output int who);
      int          exp;
      int          len;
      logic [31:0] d;
      bit          aw_done, w_done;
      exp = model_pick();
      #1;
      chk("decision_no_valid", {mem.arvalid, mem.awvalid, mem.wvalid}, 64'h0);
      @(negedge clk);
      #1;
      who = mem.awvalid ? 2 : (mem.arvalid ? (mem.araddr[31] ? 1 : 0) : -1);
      chk("grant", who, exp);
      if (who == 0 || who == 1) begin
         len = (who == 1) ? lsu_len : ifu_len;
         chk("m_araddr", mem.araddr, (who == 1) ? lsu_addr : ifu_addr);
         chk("m_arlen", mem.arlen, len);
         chk("m_arid", mem.arid, 64'h0);
         mem.arready = 1;
         #1;
         chk("x_arready", (who == 1) ? lsu.arready : ifu.arready, 64'h1);
         chk("other_arready", (who == 1) ? ifu.arready : lsu.arready, 64'h0);
         @(negedge clk);
         mem.arready = 0;
         if (who == 1) lsu.arvalid = 0; else ifu.arvalid = 0;
         for (int b = 0; b <= len; b++) begin
            d = (b == 0) ? d0 : $urandom;
            if (mid_lsu && b == 1) req_lsu(32'h8000_0040, 0);
            mem.rvalid = 1; mem.rdata = d; mem.rresp = resp; mem.rlast = (b == len);
            if (who == 1) lsu.rready = 1; else ifu.rready = 1;
            #1;
            chk("x_rvalid", (who == 1) ? lsu.rvalid : ifu.rvalid, 64'h1);
            chk("x_rdata", (who == 1) ? lsu.rdata : ifu.rdata, d);
            chk("x_rlast", (who == 1) ? lsu.rlast : ifu.rlast, (b == len));
            chk("x_rresp", (who == 1) ? lsu.rresp : ifu.rresp, resp);
            chk("other_rvalid", (who == 1) ? ifu.rvalid : lsu.rvalid, 64'h0);
            chk("rd_no_aw", mem.awvalid, 64'h0);
            if (mid_lsu) chk("mid_lsu_arready", lsu.arready, 64'h0);
            @(negedge clk);
         end
      end else if (who == 2) begin
         aw_done = 0; w_done = 0;
         chk("m_awid_len_burst", {mem.awid, mem.awlen, mem.awburst}, {4'h0, 8'h0, 2'b01});
         for (int cyc = 0; cyc < 20 && !(aw_done && w_done); cyc++) begin
            mem.awready = !aw_done && (cyc >= aw_dly);
            mem.wready  = !w_done && (cyc >= w_dly);
            #1;
            chk("wr_no_arvalid", mem.arvalid, 64'h0);
            if (!aw_done) chk("wr_awaddr", {mem.awvalid, mem.awaddr}, {1'b1, aw_addr});
            if (!w_done) chk("wr_wdata", {mem.wvalid, mem.wdata}, {1'b1, w_data});
            chk("wr_readies", {lsu.awready, lsu.wready}, {mem.awready, mem.wready});
            @(negedge clk);
            if (mem.awready) begin aw_done = 1; lsu.awvalid = 0; end
            if (mem.wready)  begin w_done = 1;  lsu.wvalid = 0;  end
            mem.awready = 0; mem.wready = 0;
         end
         mem.bvalid = 1; mem.bresp = resp; lsu.bready = 1;
         #1;
         chk("lsu_bvalid_bresp", {lsu.bvalid, lsu.bresp}, {1'b1, resp});
         chk("m_bready", mem.bready, 64'h1);
         chk("wr_no_arvalid_b", mem.arvalid, 64'h0);
         @(negedge clk);
         lsu.bready = 0;
      end
      // Bubble: stale slave valids and ready masters must not leak through.
      mem.rvalid = 1; mem.rlast = 1; mem.bvalid = 1; ifu.rready = 1; lsu.rready = 1; lsu.bready = 1;
      #1;
      chk_idle("bubble_idle");
      mem.rvalid = 0; mem.rlast = 0; mem.bvalid = 0; ifu.rready = 0; lsu.rready = 0; lsu.bready = 0;
      case (exp)
         0: begin pend_ifu = 0; last_served = 0; end
         1: begin pend_lsu = 0; last_served = 1; end
         2: pend_wr = 0;
         default: ;
      endcase
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tv[8];
      int   who;
      int   exp_seq[4];

      // Arbitration decisions straight out of reset.
      tv[0] = '{0, 0, 0, -1};
      tv[1] = '{1, 0, 0, 0};
      tv[2] = '{0, 1, 0, 1};
      tv[3] = '{0, 0, 1, 2};
      tv[4] = '{1, 1, 0, 1};
      tv[5] = '{1, 0, 1, 2};
      tv[6] = '{0, 1, 1, 2};
      tv[7] = '{1, 1, 1, 2};
      for (int i = 0; i < 8; i++) begin
         do_reset();
         if (tv[i].ir) req_ifu(32'h3000_0010, 0);
         if (tv[i].lr) req_lsu(32'h8000_0010, 0);
         if (tv[i].wr) req_wr(32'h8000_1000, 32'h0bad_f00d);
         serve(0, 0, 2'b00, $urandom, 0, who);
         chk("table_grant", who, tv[i].exp);
      end

      // Single IFU fetch.
      do_reset();
      req_ifu(32'h3000_0000, 0);
      serve(0, 0, 2'b00, 32'hDEAD_BEEF, 0, who);
      chk("single_fetch_grant", who, 0);

      // IFU burst of 4 with an LSU read raised mid-burst.
      do_reset();
      req_ifu(32'h3000_0100, 3);
      serve(0, 0, 2'b00, 32'h1234_5678, 1, who);
      chk("burst_grant", who, 0);
      serve(0, 0, 2'b00, 32'h5555_aaaa, 0, who);
      chk("after_burst_lsu", who, 1);

      // Both readers held high for four transactions.
`ifdef YSYX_25040111_ARB_RR_EN
      exp_seq = '{1, 0, 1, 0};
`else
      exp_seq = '{1, 1, 1, 1};
`endif
      do_reset();
      for (int k = 0; k < 4; k++) begin
         if (!pend_ifu) req_ifu(32'h3000_0200 + 32'(k * 4), 0);
         if (!pend_lsu) req_lsu(32'h8000_0200 + 32'(k * 4), 0);
         serve(0, 0, 2'b00, $urandom, 0, who);
         chk("contention_seq", who, exp_seq[k]);
      end
      serve(0, 0, 2'b00, $urandom, 0, who);

      // Write with W first, AW three cycles late, SLVERR response.
      do_reset();
      req_wr(32'h8000_2000, 32'hCAFE_F00D);
      req_lsu(32'h8000_3000, 0);
      req_ifu(32'h3000_0300, 0);
      serve(3, 0, 2'b10, $urandom, 0, who);
      chk("write_first", who, 2);
      serve(0, 0, 2'b11, $urandom, 0, who);
      serve(0, 0, 2'b00, $urandom, 0, who);

      // Reset in the middle of an LSU burst read.
      do_reset();
      req_lsu(32'h8000_0400, 3);
      lsu_len = 3;
      #1;
      @(negedge clk);
      #1;
      chk("rst_rd_granted", {mem.arvalid, mem.araddr}, {1'b1, 32'h8000_0400});
      mem.arready = 1;
      @(negedge clk);
      mem.arready = 0; lsu.arvalid = 0; pend_lsu = 0;
      mem.rvalid = 1; mem.rdata = 32'h1111_1111; mem.rlast = 0; lsu.rready = 1;
      #1;
      chk("rst_pre_rvalid", {lsu.rvalid, lsu.rdata}, {1'b1, 32'h1111_1111});
      rst = 1;
      @(negedge clk);
      rst = 0; mem.rdata = 32'h2222_2222; mem.rlast = 1;
      #1;
      chk_idle("rst_mid_read_idle");
      chk("rst_late_rdata", lsu.rdata, 64'h0);
      @(negedge clk);
      mem.rvalid = 0; mem.rlast = 0; lsu.rready = 0;

      // Randomized traffic against the model.
      do_reset();
      for (int it = 0; it < 40; it++) begin
         if (!pend_ifu && $urandom_range(0, 1) == 1)
            req_ifu(32'h3000_0000 | ($urandom & 32'h000f_fffc), $urandom_range(0, 3));
         if (!pend_lsu && $urandom_range(0, 1) == 1)
            req_lsu(32'h8000_0000 | ($urandom & 32'h000f_fffc), $urandom_range(0, 1));
         if (!pend_wr && $urandom_range(0, 3) == 0)
            req_wr(32'h8010_0000 | ($urandom & 32'h000f_fffc), $urandom);
         serve($urandom_range(0, 3), $urandom_range(0, 3), 2'($urandom_range(0, 3)),
               $urandom, 0, who);
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
